// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode seven-segment display.
// Double-buffered frame; new frames take effect only at frame boundaries.
module seg_scan_ctrl #(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned CLKS_PER_DIGIT = 50000,
    parameter int unsigned BLANK_CLKS     = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_load,
    input  logic [5*N_DIGITS-1:0]       i_value,
    input  logic [N_DIGITS-1:0]         i_dp,
    output logic [6:0]                  o_seg,
    output logic                        o_decimal,
    output logic [N_DIGITS-1:0]         o_an,
    output logic [$clog2(N_DIGITS)-1:0] o_digit_idx,
    output logic                        o_frame,
    output logic                        o_pending
);

    localparam int unsigned TW = $clog2(CLKS_PER_DIGIT);
    localparam int unsigned IW = $clog2(N_DIGITS);

    localparam logic [TW-1:0]         LastTick   = TW'(CLKS_PER_DIGIT - 1);
    localparam logic [TW-1:0]         LastBlank  = TW'(BLANK_CLKS - 1);
    localparam logic [IW-1:0]         LastIdx    = IW'(N_DIGITS - 1);
    localparam logic [5*N_DIGITS-1:0] BlankFrame = {N_DIGITS{5'd31}};

    typedef enum logic [1:0] {StOff, StBlank, StOn} state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  frame_q, frame_d;
    logic [5*N_DIGITS-1:0] active_q, active_d;
    logic [N_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [5*N_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                  pending_q, pending_d;

    logic [4:0]            cur_code;
    logic                  cur_dp;

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        frame_d = 1'b0;
        if (!i_en) begin
            state_d = StOff;
            timer_d = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StBlank;
                    timer_d = '0;
                    idx_d   = '0;
                    frame_d = 1'b1;
                end
                StBlank: begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q == LastBlank) state_d = StOn;
                end
                StOn: begin
                    if (timer_q == LastTick) begin
                        timer_d = '0;
                        state_d = StBlank;
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StOff;
                    timer_d = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Buffers swap during the o_frame cycle, before digit 0 leaves BLANK,
    // so a load coinciding with o_frame lands straight in the new frame.
    always_comb begin
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pending_d   = pending_q;
        if (frame_q) begin
            pending_d = 1'b0;
            if (i_load) begin
                active_d    = i_value;
                active_dp_d = i_dp;
            end else if (pending_q) begin
                active_d    = pend_val_q;
                active_dp_d = pend_dp_q;
            end
        end else if (i_load) begin
            pend_val_d = i_value;
            pend_dp_d  = i_dp;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StOff;
            timer_q     <= '0;
            idx_q       <= '0;
            frame_q     <= 1'b0;
            active_q    <= BlankFrame;
            active_dp_q <= '0;
            pend_val_q  <= BlankFrame;
            pend_dp_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pending_q   <= pending_d;
        end
    end

    assign cur_code = active_q[idx_q*5 +: 5];
    assign cur_dp   = active_dp_q[idx_q];

    always_comb begin
        o_seg     = 7'h7F;
        o_decimal = 1'b1;
        o_an      = '1;
        if (state_q == StOn) begin
            o_an[idx_q] = 1'b0;
            o_seg       = seg_decode(cur_code);
            o_decimal   = ~cur_dp;
        end
    end

    assign o_digit_idx = idx_q;
    assign o_frame     = frame_q;
    assign o_pending   = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIGITS=4, CLKS_PER_DIGIT=8, BLANK_CLKS=2.
// Outputs are sampled on the falling edge; k counts cycles since the scan started.
module tb_seg_scan_ctrl;

    localparam int N   = 4;
    localparam int CPD = 8;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [19:0] value;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        dec;
    logic [3:0]  an;
    logic [1:0]  idx;
    logic        frame;
    logic        pend;

    int n_checks = 0;
    int n_fail   = 0;
    int k;

    logic [6:0] seg_tab [4];
    logic [3:0] dec_tab;

    seg_scan_ctrl #(
        .N_DIGITS      (N),
        .CLKS_PER_DIGIT(CPD),
        .BLANK_CLKS    (BLK)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_load     (load),
        .i_value    (value),
        .i_dp       (dp),
        .o_seg      (seg),
        .o_decimal  (dec),
        .o_an       (an),
        .o_digit_idx(idx),
        .o_frame    (frame),
        .o_pending  (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic set_tab(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [3:0] d);
        seg_tab[0] = s0;
        seg_tab[1] = s1;
        seg_tab[2] = s2;
        seg_tab[3] = s3;
        dec_tab    = d;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, " an"}, {28'd0, an}, 32'hF);
        chk({tag, " seg"}, {25'd0, seg}, 32'h7F);
        chk({tag, " dec"}, {31'd0, dec}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk_dark(tag);
        chk({tag, " idx"}, {30'd0, idx}, 32'd0);
        chk({tag, " frame"}, {31'd0, frame}, 32'd0);
        chk({tag, " pend"}, {31'd0, pend}, 32'd0);
    endtask

    // Expected outputs at cycle k of a running scan.
    task automatic expect_slot(input string tag);
        int         ph;
        int         sl;
        logic [3:0] an_exp;
        ph = k % CPD;
        sl = (k / CPD) % N;
        chk($sformatf("%s k=%0d frame", tag, k), {31'd0, frame}, {31'd0, (k % (N * CPD)) == 0});
        chk($sformatf("%s k=%0d idx", tag, k), {30'd0, idx}, sl);
        if (ph < BLK) begin
            chk_dark($sformatf("%s k=%0d blank", tag, k));
        end else begin
            an_exp = 4'b0001 << sl;
            an_exp = ~an_exp;
            chk($sformatf("%s k=%0d an", tag, k), {28'd0, an}, {28'd0, an_exp});
            chk($sformatf("%s k=%0d seg", tag, k), {25'd0, seg}, {25'd0, seg_tab[sl]});
            chk($sformatf("%s k=%0d dec", tag, k), {31'd0, dec}, {31'd0, dec_tab[sl]});
        end
    endtask

    // At most one anode may ever be driven low.
    always @(negedge clk) begin
        chk("one_anode", {31'd0, $countones(~an) <= 1}, 32'd1);
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        value = '0;
        dp    = '0;
        k     = 0;
        set_tab(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);

        #12;
        chk_reset("reset");
        @(negedge clk);
        chk_reset("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_reset("off_idle");

        // Blank frame scan straight out of reset
        en = 1'b1;
        k  = -1;
        repeat (40) begin
            tick();
            expect_slot("t1");
            chk("t1 pend", {31'd0, pend}, 32'd0);
        end

        // Load while dark, then enable
        en = 1'b0;
        tick();
        chk_dark("t2 off");
        value = {5'd3, 5'd2, 5'd1, 5'd0};
        dp    = 4'b0100;
        load  = 1'b1;
        tick();
        load = 1'b0;
        chk("t2 pend set", {31'd0, pend}, 32'd1);
        chk_dark("t2 off load");

        en = 1'b1;
        k  = -1;
        set_tab(7'h40, 7'h79, 7'h24, 7'h30, 4'b1011);
        while (k < 43) begin
            tick();
            expect_slot("t2");
            chk($sformatf("t2 k=%0d pend", k), {31'd0, pend}, {31'd0, k == 0});
        end

        // Mid-frame load, double load, load on the o_frame cycle
        value = {4{5'd8}};
        dp    = 4'b0000;
        load  = 1'b1;
        while (k < 179) begin
            tick();
            load = 1'b0;
            if (k == 64) set_tab(7'h00, 7'h00, 7'h00, 7'h00, 4'hF);
            if (k == 96) set_tab(7'h02, 7'h02, 7'h02, 7'h02, 4'hF);
            if (k == 128) set_tab(7'h19, 7'h78, 7'h7F, 7'h7F, 4'b0110);
            expect_slot("t34");
            chk($sformatf("t34 k=%0d pend", k), {31'd0, pend},
                {31'd0, (k >= 44 && k <= 64) || (k >= 71 && k <= 96)});
            if (k == 70) begin
                value = {4{5'd5}};
                load  = 1'b1;
            end
            if (k == 80) begin
                value = {4{5'd6}};
                load  = 1'b1;
            end
            if (k == 128) begin
                value = {5'd31, 5'd10, 5'd7, 5'd4};
                dp    = 4'b1001;
                load  = 1'b1;
            end
        end

        // Drop enable during digit 2 ON, then restart with retained values
        chk("t5 on digit2", {28'd0, an}, 32'hB);
        en = 1'b0;
        tick();
        chk_dark("t5 dark");
        chk("t5 idx", {30'd0, idx}, 32'd0);
        chk("t5 frame", {31'd0, frame}, 32'd0);
        tick();
        chk_dark("t5 dark2");
        en = 1'b1;
        k  = -1;
        while (k < 44) begin
            tick();
            expect_slot("t5");
            chk($sformatf("t5 k=%0d pend", k), {31'd0, pend}, 32'd0);
        end

        // Asynchronous reset mid-slot clears everything immediately
        chk("t6 on digit1", {28'd0, an}, 32'hD);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("t6 async");
        @(negedge clk);
        chk_reset("t6 held");
        rst = 1'b0;
        k   = -1;
        set_tab(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
        repeat (33) begin
            tick();
            expect_slot("t6");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
